// File: rtl/iob_reg_rr_arb_if.sv
// ---------------------------------------------------------------------------
// iob_reg_rr_arb_if
// Bus bundle between the requesters and the round-robin register arbiter.
//   req_i   : per-requester write request (level), driven by requesters
//   data_i  : packed requester data, requester k at [k*DATA_W +: DATA_W]
//   ack_o   : one-hot write acknowledge, driven by the arbiter
//   busy_o  : arbiter is in its WRITE state
//   data_o  : shared register contents
//   owner_o : index of the requester that performed the last write
//   upd_o   : one-cycle pulse, data_o/owner_o carry a fresh write
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface iob_reg_rr_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ-1:0]        ack_o;
  logic                    busy_o;
  logic [DATA_W-1:0]       data_o;
  logic [IDX_W-1:0]        owner_o;
  logic                    upd_o;

  modport master (
    output req_i, data_i,
    input  ack_o, busy_o, data_o, owner_o, upd_o
  );

  modport slave (
    input  req_i, data_i,
    output ack_o, busy_o, data_o, owner_o, upd_o
  );
endinterface

// File: rtl/iob_reg_rr_arb.sv
// ---------------------------------------------------------------------------
// iob_reg_rr_arb
// Round-robin write arbiter in front of one shared clock-enabled register.
// Each transaction takes two cycles: IDLE picks a winner scanning upward
// from the round-robin pointer, WRITE acknowledges and loads the register
// if the winner still requests.
// Ports:
//   clk_i : rising-edge clock
//   cke_i : clock enable, 0 freezes all state and forces ack_o low
//   rst_i : synchronous active-high reset, wins over cke_i
//   bus   : iob_reg_rr_arb_if.slave (req/data in, ack/busy/data/owner/upd out)
// ---------------------------------------------------------------------------
module iob_reg_rr_arb #(
  parameter int                N_REQ   = 4,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  parameter int                IDX_W   = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             rst_i,
  iob_reg_rr_arb_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  grant_r;
  logic [IDX_W-1:0]  grant_nxt_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic              win_found_s;
  logic [IDX_W:0]    scan_s;
  logic [IDX_W:0]    inc_s;
  logic [IDX_W-1:0]  grant_inc_s;
  logic              wr_s;
  logic [DATA_W-1:0] data_sel_s;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  owner_r;
  logic              upd_r;

  // Winner search: first set request at or above rr_ptr, wrapping at N_REQ.
  // scan_s is one bit wider so rr_ptr+i cannot overflow before the wrap.
  always_comb begin
    win_idx_s   = {IDX_W{1'b0}};
    win_found_s = 1'b0;
    scan_s      = {(IDX_W+1){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      scan_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
      if (scan_s >= (IDX_W+1)'(N_REQ)) begin
        scan_s = scan_s - (IDX_W+1)'(N_REQ);
      end else begin
        scan_s = scan_s;
      end
      if (!win_found_s && bus.req_i[scan_s[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_s[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pointer that follows the current grant, (grant+1) mod N_REQ.
  always_comb begin
    inc_s = {1'b0, grant_r} + {{IDX_W{1'b0}}, 1'b1};
    if (inc_s >= (IDX_W+1)'(N_REQ)) begin
      grant_inc_s = {IDX_W{1'b0}};
    end else begin
      grant_inc_s = inc_s[IDX_W-1:0];
    end
  end

  // Data word of the latched grant.
  always_comb begin
    data_sel_s = {DATA_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_r == IDX_W'(k)) begin
        data_sel_s = bus.data_i[k*DATA_W +: DATA_W];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  // A WRITE cycle completes only if the granted requester still asks.
  assign wr_s = (state_r == WRITE) && bus.req_i[grant_r];

  // State and datapath registers; reset first, then clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      rr_ptr_r <= {IDX_W{1'b0}};
      grant_r  <= {IDX_W{1'b0}};
      data_r   <= RST_VAL;
      owner_r  <= {IDX_W{1'b0}};
      upd_r    <= 1'b0;
    end else if (cke_i) begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      if (wr_s) begin
        data_r   <= data_sel_s;
        owner_r  <= grant_r;
        upd_r    <= 1'b1;
        rr_ptr_r <= grant_inc_s;
      end else begin
        upd_r <= 1'b0;
      end
    end
  end

  // Next-state logic; a withdrawn grant simply falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = WRITE;
          grant_nxt_s = win_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs: ack is combinational from WRITE and suppressed while frozen
  // or in reset, so an aborted transaction is never acknowledged.
  always_comb begin
    bus.ack_o   = {N_REQ{1'b0}};
    bus.busy_o  = (state_r == WRITE);
    bus.data_o  = data_r;
    bus.owner_o = owner_r;
    bus.upd_o   = upd_r;
    if (wr_s && cke_i && !rst_i) begin
      bus.ack_o = N_REQ'(1) << grant_r;
    end else begin
      bus.ack_o = {N_REQ{1'b0}};
    end
  end

endmodule
